shift_cmd_sequencer: RTL and testbench

Command sequencer between the debounced button strobes and the 64-bit LED/matrix shift register. It queues shift-right/shift-left requests from the buttons and from an internal auto-rotate timer. It issues them to the shift register one at a time, aligned to the CE tick. After each shift it waits a settle interval and emits a reload strobe so all 16 PWM channels latch the new duty nibbles together.

---
 rtl/shift_cmd_sequencer_if.sv | 27 ++
 rtl/shift_cmd_sequencer.sv | 105 ++++++++++
 tb/tb_shift_cmd_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_sequencer_if.sv
// shift_cmd_sequencer_if: button/auto request inputs and shift/reload strobe outputs of the command sequencer
interface shift_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          ce;
    logic                          req_r;
    logic                          req_l;
    logic                          auto_en;
    logic                          auto_dir;
    logic                          clr_ovf;
    logic                          shift_r;
    logic                          shift_l;
    logic                          re;
    logic [$clog2(FIFO_DEPTH):0]   fifo_lvl;
    logic                          ovf;
    logic                          idle;

    modport master (
        output ce, req_r, req_l, auto_en, auto_dir, clr_ovf,
        input  shift_r, shift_l, re, fifo_lvl, ovf, idle
    );

    modport slave (
        input  ce, req_r, req_l, auto_en, auto_dir, clr_ovf,
        output shift_r, shift_l, re, fifo_lvl, ovf, idle
    );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: queues shift requests and issues them on CE ticks, each followed by a settled reload strobe
module shift_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int AUTO_PERIOD = 100,
    parameter int SETTLE      = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    shift_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(AUTO_PERIOD);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] AUTO_LAST   = CW'(AUTO_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [AW:0]   FULL_LVL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_SETTLE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           lvl;
    logic [CW-1:0]         auto_cnt;
    logic [SW-1:0]         settle_cnt;
    logic [SW-1:0]         settle_nxt;
    logic                  btn_push;
    logic                  auto_tick;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  push_dir;
    logic                  ovf_set;
    logic                  shift_r_nxt;
    logic                  shift_l_nxt;
    logic                  re_nxt;

    // simultaneous R and L requests cancel each other
    assign btn_push  = bus.req_r ^ bus.req_l;
    assign auto_tick = bus.auto_en && bus.ce && auto_cnt == AUTO_LAST;
    assign full      = lvl == FULL_LVL;
    assign pop       = state == S_IDLE && bus.ce && lvl != '0;
    assign push      = btn_push ? (!full || pop) : (auto_tick && lvl == '0 && !bus.req_r && !bus.req_l);
    assign push_dir  = btn_push ? bus.req_l : bus.auto_dir;
    assign ovf_set   = btn_push && full && !pop;

    assign bus.fifo_lvl = lvl;
    assign bus.idle     = state == S_IDLE && lvl == '0;

    always_comb begin
        state_nxt   = state;
        settle_nxt  = settle_cnt;
        shift_r_nxt = 1'b0;
        shift_l_nxt = 1'b0;
        re_nxt      = 1'b0;
        if (state == S_IDLE) begin
            if (pop) begin
                shift_r_nxt = !mem[rd_ptr];
                shift_l_nxt = mem[rd_ptr];
                settle_nxt  = '0;
                state_nxt   = S_SETTLE;
            end
        end else if (bus.ce) begin
            settle_nxt = settle_cnt + SW'(1);
            if (settle_cnt == SETTLE_LAST) begin
                re_nxt     = 1'b1;
                settle_nxt = '0;
                state_nxt  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            settle_cnt  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lvl         <= '0;
            auto_cnt    <= '0;
            bus.ovf     <= 1'b0;
            bus.shift_r <= 1'b0;
            bus.shift_l <= 1'b0;
            bus.re      <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            bus.shift_r <= shift_r_nxt;
            bus.shift_l <= shift_l_nxt;
            bus.re      <= re_nxt;
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
            lvl         <= lvl + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            auto_cnt    <= !bus.auto_en ? '0 : !bus.ce ? auto_cnt : auto_tick ? '0 : auto_cnt + CW'(1);
            // a fresh overflow outranks a clear in the same cycle
            bus.ovf     <= ovf_set || (bus.ovf && !bus.clr_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dir;
    end
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb_shift_cmd_sequencer: directed stimulus with a strobe scoreboard checked by an independent monitor
module tb_shift_cmd_sequencer;
    localparam int FD = 4;
    localparam int AP = 5;
    localparam int ST = 2;

    logic clk;
    logic rst_n;
    logic ce_gen;
    logic ce_man;
    logic ce_run;
    int   ph;
    int   ce_seen;
    int   n_vec;
    int   n_err;
    int   exp_q[$];
    int   last_shift_ce;
    int   prev_shift_ce;
    int   last_re_ce;
    int   e0;

    shift_cmd_sequencer_if #(.FIFO_DEPTH(FD)) intf ();

    shift_cmd_sequencer #(.FIFO_DEPTH(FD), .AUTO_PERIOD(AP), .SETTLE(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    assign intf.ce = ce_gen | ce_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CE every 4th clock while ce_run is set
    initial begin
        ce_gen = 1'b0;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            ce_gen = ce_run && ph == 0;
        end
    end

    initial ce_seen = 0;
    always @(posedge clk) if (intf.ce) ce_seen <= ce_seen + 1;

    // codes: 0 = SHIFT_R, 1 = SHIFT_L, 2 = RE
    always @(negedge clk) begin
        int code;
        int want;
        if (!rst_n) begin
            last_shift_ce = -100;
            prev_shift_ce = -100;
            last_re_ce    = -100;
        end else if (intf.shift_r || intf.shift_l || intf.re) begin
            code = intf.re ? 2 : intf.shift_l ? 1 : 0;
            n_vec++;
            if (int'(intf.shift_r) + int'(intf.shift_l) + int'(intf.re) > 1) begin
                n_err++;
                $display("FAIL strobe_overlap got r=%0b l=%0b re=%0b required one", intf.shift_r, intf.shift_l, intf.re);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL strobe_order got=%0d required=none", code);
            end else begin
                want = exp_q.pop_front();
                if (want != code) begin
                    n_err++;
                    $display("FAIL strobe_order got=%0d required=%0d", code, want);
                end
            end
            n_vec++;
            if (code == 2) begin
                if (ce_seen - last_shift_ce != ST) begin
                    n_err++;
                    $display("FAIL settle_gap got=%0d required=%0d", ce_seen - last_shift_ce, ST);
                end
                last_re_ce = ce_seen;
            end else begin
                if (ce_seen - last_re_ce < 1) begin
                    n_err++;
                    $display("FAIL issue_gap got=%0d required>=1", ce_seen - last_re_ce);
                end
                prev_shift_ce = last_shift_ce;
                last_shift_ce = ce_seen;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_shift_r"}, 32'(intf.shift_r), 0);
        chk({name, "_shift_l"}, 32'(intf.shift_l), 0);
        chk({name, "_re"}, 32'(intf.re), 0);
        chk({name, "_lvl"}, 32'(intf.fifo_lvl), 0);
        chk({name, "_ovf"}, 32'(intf.ovf), 0);
        chk({name, "_idle"}, 32'(intf.idle), 1);
    endtask

    task automatic drive(input logic r, input logic l);
        intf.req_r = r;
        intf.req_l = l;
        @(negedge clk);
        intf.req_r = 1'b0;
        intf.req_l = 1'b0;
    endtask

    task automatic ce_pulse();
        ce_man = 1'b1;
        @(negedge clk);
        ce_man = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_cmds(input int dir, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(dir);
            exp_q.push_back(2);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && intf.idle) && n < 600) begin
            @(posedge clk);
            n++;
        end
        n_vec++;
        if (n >= 600) begin
            n_err++;
            $display("FAIL %s_timeout got pending=%0d required=0", name, exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic wait_q(input string name, input int size);
        int n = 0;
        while (exp_q.size() > size && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 600) begin
            n_err++;
            $display("FAIL %s_timeout got pending=%0d required=%0d", name, exp_q.size(), size);
        end
    endtask

    task automatic wait_ce(input string name, input int target);
        int n = 0;
        while (ce_seen < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 600) begin
            n_err++;
            $display("FAIL %s_timeout got ce=%0d required=%0d", name, ce_seen, target);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ce_run = 1'b0;
        ce_man = 1'b0;
        intf.req_r = 1'b0;
        intf.req_l = 1'b0;
        intf.auto_en = 1'b0;
        intf.auto_dir = 1'b0;
        intf.clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        ce_run = 1'b1;
        expect_cmds(0, 1);
        drive(1'b1, 1'b0);
        chk("single_lvl", 32'(intf.fifo_lvl), 1);
        wait_done("single");

        expect_cmds(0, 1);
        expect_cmds(1, 2);
        expect_cmds(0, 1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        wait_done("order");

        ce_run = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
        chk("ovf_lvl", 32'(intf.fifo_lvl), 4);
        chk("ovf_set", 32'(intf.ovf), 1);
        drive(1'b1, 1'b1);
        chk("collide_full_lvl", 32'(intf.fifo_lvl), 4);
        chk("collide_full_ovf", 32'(intf.ovf), 1);
        intf.clr_ovf = 1'b1;
        @(negedge clk);
        intf.clr_ovf = 1'b0;
        chk("ovf_clr", 32'(intf.ovf), 0);
        chk("full_not_idle", 32'(intf.idle), 0);
        expect_cmds(1, 4);
        expect_cmds(0, 1);
        ce_man = 1'b1;
        intf.req_r = 1'b1;
        @(negedge clk);
        ce_man = 1'b0;
        intf.req_r = 1'b0;
        chk("pushpop_lvl", 32'(intf.fifo_lvl), 4);
        chk("pushpop_ovf", 32'(intf.ovf), 0);
        ce_run = 1'b1;
        wait_done("overflow");

        ce_run = 1'b0;
        repeat (2) @(negedge clk);
        drive(1'b1, 1'b1);
        chk("collide_lvl", 32'(intf.fifo_lvl), 0);
        chk("collide_ovf", 32'(intf.ovf), 0);

        intf.auto_en = 1'b1;
        intf.auto_dir = 1'b1;
        repeat (4) ce_pulse();
        chk("auto_quiet_lvl", 32'(intf.fifo_lvl), 0);
        expect_cmds(0, 1);
        ce_man = 1'b1;
        intf.req_r = 1'b1;
        @(negedge clk);
        ce_man = 1'b0;
        intf.req_r = 1'b0;
        intf.auto_en = 1'b0;
        chk("auto_collide_lvl", 32'(intf.fifo_lvl), 1);
        ce_run = 1'b1;
        wait_done("auto_collide");

        expect_cmds(1, 3);
        e0 = ce_seen;
        intf.auto_en = 1'b1;
        wait_ce("auto_run", e0 + 17);
        intf.auto_en = 1'b0;
        wait_done("auto_run");
        chk("auto_first", 32'(prev_shift_ce - e0), 11);
        chk("auto_period", 32'(last_shift_ce - prev_shift_ce), 5);

        repeat (23) @(negedge clk);
        chk("auto_stopped", 32'(exp_q.size()), 0);
        expect_cmds(1, 1);
        e0 = ce_seen;
        intf.auto_en = 1'b1;
        wait_q("auto_restart", 1);
        intf.auto_en = 1'b0;
        chk("auto_restart", 32'(last_shift_ce - e0), 6);
        wait_done("auto_restart");

        exp_q.push_back(0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        wait_q("rst_pre", 0);
        chk("rst_pre_lvl", 32'(intf.fifo_lvl), 3);
        chk("rst_pre_idle", 32'(intf.idle), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid_rst");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_idle", 32'(intf.idle), 1);
        chk("post_rst_lvl", 32'(intf.fifo_lvl), 0);
        chk("exp_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
